// File: rtl/knn_local_buf_pkg.sv
// knn_local_buf_pkg
// Shared types and constants for the kNN local-buffer arbiter.
//   gnt_e      : per-cycle grant decision (none / write side / read side)
//   STAT_WIDTH : width of the optional statistics counters
//   cnt_width  : bit width needed to hold an occupancy count 0..depth
package knn_local_buf_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    localparam int STAT_WIDTH = 32;

    // Occupancy counters must be able to represent "completely full".
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/knn_local_buf_arbiter_if.sv
// knn_local_buf_arbiter_if
// Requester-side bundle of the local-buffer arbiter.
//   wr_*  : write request channel (point loader), valid/ready
//   rd_*  : read request channel (distance compute), valid/ready
//   rsp_* : read response stream back to the compute side, valid/ready
// master = requesters, slave = arbiter.
interface knn_local_buf_arbiter_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 11
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/knn_rsp_fifo.sv
// knn_rsp_fifo
// Small synchronous FIFO holding read responses until the consumer takes them.
//   clk, reset : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data : enqueue (ignored when full; the caller's credit scheme avoids that)
//   pop, pop_data   : dequeue; pop_data is the registered head entry
//   empty, count    : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module knn_rsp_fifo
    import knn_local_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       pop_data,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] store_r [DEPTH];
    logic [PTR_W-1:0]      wptr_r;
    logic [PTR_W-1:0]      rptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        do_push_s = push && (count_r != CNT_W'(DEPTH));
        do_pop_s  = pop && (count_r != '0);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Data storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            store_r[wptr_r] <= push_data;
        end
    end

    assign pop_data = store_r[rptr_r];
    assign empty    = (count_r == '0);
    assign count    = count_r;

endmodule

// File: rtl/knn_local_buf_arbiter.sv
// knn_local_buf_arbiter
// Shares one single-port local buffer between a write requester and a read
// requester, one access per cycle, round-robin on contention. Read data is
// tracked through the memory latency and returned in order via a response FIFO.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   bus (slave) : wr/rd request channels and rsp stream (knn_local_buf_arbiter_if)
//   mem_*       : buffer port 0 (address0, ce0, we0, d0 out; q0 in)
//   stat_*      : write/read/conflict counters, present only with KNN_ARB_STATS_EN
// Optional feature macro: KNN_ARB_STATS_EN.
module knn_local_buf_arbiter
    import knn_local_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 11,
    parameter int MEM_LATENCY = 2,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    knn_local_buf_arbiter_if.slave bus,
    output logic [ADDR_WIDTH-1:0] mem_address0,
    output logic                  mem_ce0,
    output logic                  mem_we0,
    output logic [DATA_WIDTH-1:0] mem_d0,
    input  logic [DATA_WIDTH-1:0] mem_q0
`ifdef KNN_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_wr_cnt,
    output logic [STAT_WIDTH-1:0] stat_rd_cnt,
    output logic [STAT_WIDTH-1:0] stat_conflict_cnt
`endif
);
    localparam int CNT_W = cnt_width(RSP_DEPTH);

    gnt_e                   gnt_s;
    gnt_e                   rr_r;
    logic [MEM_LATENCY-1:0] rd_tag_r;
    logic [CNT_W-1:0]       fifo_count_s;
    logic [CNT_W-1:0]       inflight_s;
    logic [CNT_W:0]         credit_used_s;
    logic                   rd_ok_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   fifo_empty_s;
    logic [DATA_WIDTH-1:0]  fifo_head_s;

    // Count reads still travelling through the memory pipeline.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight_s = inflight_s + CNT_W'(rd_tag_r[i]);
        end
    end

    // A read may only issue if a FIFO slot is reserved for its data; a pop in
    // the same cycle deliberately does not free a credit (keeps the path short).
    always_comb begin
        credit_used_s = {1'b0, fifo_count_s} + {1'b0, inflight_s};
        rd_ok_s       = bus.rd_valid && (credit_used_s < (CNT_W + 1)'(RSP_DEPTH));
    end

    // Round-robin grant: on contention the side not granted last time wins.
    always_comb begin
        gnt_s = GNT_NONE;
        if (!reset) begin
            gnt_s = GNT_NONE;
        end else if (bus.wr_valid && rd_ok_s) begin
            gnt_s = (rr_r == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (bus.wr_valid) begin
            gnt_s = GNT_WR;
        end else if (rd_ok_s) begin
            gnt_s = GNT_RD;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Drive handshakes and the memory port from the grant decision.
    always_comb begin
        bus.wr_ready = 1'b0;
        bus.rd_ready = 1'b0;
        mem_ce0      = 1'b0;
        mem_we0      = 1'b0;
        mem_address0 = '0;
        mem_d0       = '0;
        case (gnt_s)
            GNT_WR: begin
                bus.wr_ready = 1'b1;
                mem_ce0      = 1'b1;
                mem_we0      = 1'b1;
                mem_address0 = bus.wr_addr;
                mem_d0       = bus.wr_data;
            end
            GNT_RD: begin
                bus.rd_ready = 1'b1;
                mem_ce0      = 1'b1;
                mem_address0 = bus.rd_addr;
            end
            default: begin
                bus.wr_ready = 1'b0;
                bus.rd_ready = 1'b0;
            end
        endcase
    end

    // Remember the last granted side; reset to WR so a read wins first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_r <= GNT_WR;
        end else if (gnt_s != GNT_NONE) begin
            rr_r <= gnt_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Read-latency tag pipeline; the last stage marks mem_q0 as valid this cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_tag_r <= '0;
        end else begin
            rd_tag_r[0] <= (gnt_s == GNT_RD);
            for (int i = 1; i < MEM_LATENCY; i++) begin
                rd_tag_r[i] <= rd_tag_r[i-1];
            end
        end
    end

    assign push_s = rd_tag_r[MEM_LATENCY-1];
    assign pop_s  = bus.rsp_valid && bus.rsp_ready;

    knn_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (mem_q0),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign bus.rsp_valid = reset && !fifo_empty_s;
    assign bus.rsp_data  = fifo_head_s;

`ifdef KNN_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_wr_r;
    logic [STAT_WIDTH-1:0] stat_rd_r;
    logic [STAT_WIDTH-1:0] stat_conflict_r;

    // Saturating access and contention counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_wr_r       <= '0;
            stat_rd_r       <= '0;
            stat_conflict_r <= '0;
        end else begin
            if ((gnt_s == GNT_WR) && (stat_wr_r != '1)) begin
                stat_wr_r <= stat_wr_r + STAT_WIDTH'(1'b1);
            end
            if ((gnt_s == GNT_RD) && (stat_rd_r != '1)) begin
                stat_rd_r <= stat_rd_r + STAT_WIDTH'(1'b1);
            end
            // Contention counts raw requests, including credit-stalled reads.
            if (bus.wr_valid && bus.rd_valid && (stat_conflict_r != '1)) begin
                stat_conflict_r <= stat_conflict_r + STAT_WIDTH'(1'b1);
            end
        end
    end

    assign stat_wr_cnt       = stat_wr_r;
    assign stat_rd_cnt       = stat_rd_r;
    assign stat_conflict_cnt = stat_conflict_r;
`endif

endmodule
